// File: rtl/tanh_pkg.sv
// Shared constants, Q-format fraction widths and FSM encoding for the tanh series engine.
package tanh_pkg;

  localparam int N_TERMS = 8;
  localparam int AW      = $clog2(N_TERMS);
  localparam int XW      = 16;
  localparam int CW      = 17;
  localparam int RW      = 32;

  localparam int X_FRAC  = 15;
  localparam int C_FRAC  = 16;
  localparam int R_FRAC  = 30;

  localparam int PW      = 2 * RW;
  localparam int SHW     = $clog2(PW);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SQ   = 3'd1,
    HRN  = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Unsigned Q1.16 coefficient re-aligned onto the Q2.30 accumulator grid.
  function automatic logic [RW-1:0] coef_to_acc(input logic [CW-1:0] c);
    return RW'(c) << (R_FRAC - C_FRAC);
  endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// Signed full-width multiply followed by a run-time arithmetic right shift; low OUTW bits kept.
module fx_mul_shift #(
  parameter int OPW  = 32,
  parameter int OUTW = 32,
  parameter int SHW  = 6
) (
  input  logic signed [OPW-1:0]  a,
  input  logic signed [OPW-1:0]  b,
  input  logic        [SHW-1:0]  sh,
  output logic signed [OUTW-1:0] p
);

  logic signed [2*OPW-1:0] a_ext;
  logic signed [2*OPW-1:0] b_ext;
  logic signed [2*OPW-1:0] full;

  assign a_ext = {{OPW{a[OPW-1]}}, a};
  assign b_ext = {{OPW{b[OPW-1]}}, b};
  assign full  = a_ext * b_ext;
  assign p     = OUTW'(full >>> sh);

endmodule

// File: rtl/tanh_series_ctrl.sv
// Horner-rule tanh(x) sequencer: squares x, walks the coefficient LUT from c7 down to c0,
// then scales by x; one shared multiplier serves all three phases.
module tanh_series_ctrl
  import tanh_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x_in,
  input  logic [CW-1:0] lut_coef,
  output logic [AW-1:0] addr,
  output logic [RW-1:0] result_ready,
  output logic          busy,
  output logic          done
);

  state_t        state;
  state_t        state_nx;
  logic [XW-1:0] x_r;
  logic [RW-1:0] x2;
  logic [RW-1:0] acc;
  logic [AW-1:0] k;
  logic          accept;

  logic [RW-1:0]  x_ext;
  logic [RW-1:0]  mul_a;
  logic [RW-1:0]  mul_b;
  logic [SHW-1:0] mul_sh;
  logic [RW-1:0]  mul_p;

  assign accept = start && (state == IDLE || state == DONE);
  assign x_ext  = {{(RW-XW){x_r[XW-1]}}, x_r};

  fx_mul_shift #(
    .OPW  (RW),
    .OUTW (RW),
    .SHW  (SHW)
  ) u_mul (
    .a  (mul_a),
    .b  (mul_b),
    .sh (mul_sh),
    .p  (mul_p)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nx = state;
    addr     = '0;
    busy     = 1'b0;
    done     = 1'b0;
    mul_a    = x_ext;
    mul_b    = x_ext;
    mul_sh   = '0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SQ;
      end
      SQ: begin
        addr     = AW'(N_TERMS - 1);
        busy     = 1'b1;
        state_nx = HRN;
      end
      HRN: begin
        addr   = k;
        busy   = 1'b1;
        mul_a  = x2;
        mul_b  = acc;
        mul_sh = SHW'(R_FRAC);
        if (k == '0) state_nx = FIN;
      end
      FIN: begin
        busy     = 1'b1;
        mul_b    = acc;
        mul_sh   = SHW'(X_FRAC);
        state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = start ? SQ : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      x_r          <= '0;
      x2           <= '0;
      acc          <= '0;
      k            <= '0;
      result_ready <= '0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      state <= state_nx;
      if (accept) x_r <= x_in;
      unique case (state)
        SQ: begin
          x2  <= mul_p;
          acc <= coef_to_acc(lut_coef);
          k   <= AW'(N_TERMS - 2);
        end
        HRN: begin
          acc <= coef_to_acc(lut_coef) - mul_p;
          if (k != '0) k <= k - AW'(1);
        end
        FIN: result_ready <= mul_p;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tanh_series_ctrl.sv
// Directed bench for tanh_series_ctrl: timing, addr walk, start handling, async abort and
// result values against both a bit-exact series model and real tanh within tolerance.
module tb_tanh_series_ctrl;
  import tanh_pkg::*;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic [XW-1:0] x_in   = '0;
  logic [CW-1:0] lut_coef;
  logic [AW-1:0] addr;
  logic [RW-1:0] result_ready;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Magnitudes 1, 1/3, 2/15, 17/315, 62/2835, 1382/155925, 21844/6081075, 929569/638512875 in Q1.16
  logic [CW-1:0] coef_tab [N_TERMS] = '{17'h10000, 17'h05555, 17'h02222, 17'h00DD1,
                                        17'h00599, 17'h00245, 17'h000EB, 17'h0005F};

  localparam int TOL_HALF = 1 << 18;
  localparam int TOL_ONE  = 1 << 23;

  assign lut_coef = coef_tab[addr];

  always #5 clk = ~clk;

  tanh_series_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .x_in         (x_in),
    .lut_coef     (lut_coef),
    .addr         (addr),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp,
                       input int tol = 0);
    longint diff;
    checks++;
    diff = longint'($signed(got)) - longint'($signed(exp));
    if ((^got === 1'bx) || diff > longint'(tol) || diff < -longint'(tol)) begin
      errors++;
      $display("FAIL %s got=%h exp=%h tol=%0d", tag, got, exp, tol);
    end
  endtask

  function automatic logic [RW-1:0] q30(input real r);
    return RW'($rtoi(r * 1073741824.0));
  endfunction

  // Horner evaluation written directly from the series definition, in 64-bit arithmetic.
  function automatic logic [RW-1:0] model(input logic [XW-1:0] x);
    longint xs, x2, acc, p;
    xs  = longint'($signed(x));
    x2  = xs * xs;
    acc = longint'(coef_tab[N_TERMS-1]) <<< 14;
    for (int i = N_TERMS - 2; i >= 0; i--) begin
      p   = x2 * acc;
      acc = (longint'(coef_tab[i]) <<< 14) - (p >>> 30);
      acc = longint'($signed(acc[31:0]));
    end
    p = xs * acc;
    return RW'(p >>> 15);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [XW-1:0] x, output logic [RW-1:0] res,
                        output int edges, output int busy_cycles);
    start = 1'b1;
    x_in  = x;
    tick();
    start = 1'b0;
    x_in  = ~x;
    edges = 1;
    busy_cycles = busy ? 1 : 0;
    while (!done && edges < 30) begin
      tick();
      edges++;
      if (busy) busy_cycles++;
    end
    res = result_ready;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] res;
    logic [RW-1:0] prev;
    int            edges;
    int            bcyc;
    int            dcount;
    int            done_at [3];
    logic [RW-1:0] done_res [3];
    logic [XW-1:0] xs [25];
    int            exp_addr [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 0};

    // Reset state
    #1;
    check("rst_addr",   RW'(addr), '0);
    check("rst_result", result_ready, '0);
    check("rst_busy",   RW'(busy), '0);
    check("rst_done",   RW'(done), '0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Zero operand: latency, busy span, exact zero, single-cycle done
    run_op(16'h0000, res, edges, bcyc);
    check("zero_latency", RW'(edges), 32'd10);
    check("zero_busy",    RW'(bcyc),  32'd9);
    check("zero_result",  res, '0);
    tick();
    check("zero_done_low", RW'(done), '0);

    // +/-0.5 and 0.25
    run_op(16'h4000, res, edges, bcyc);
    check("p05_model", res, model(16'h4000));
    check("p05_tanh",  res, q30(0.46211716), TOL_HALF);
    run_op(16'hC000, res, edges, bcyc);
    check("m05_model", res, model(16'hC000));
    check("m05_tanh",  res, q30(-0.46211716), TOL_HALF);
    run_op(16'h2000, res, edges, bcyc);
    check("p025_model", res, model(16'h2000));
    check("p025_tanh",  res, q30(0.24491866), TOL_HALF);

    // -1.0 with the LUT address walk
    tick();
    start = 1'b1;
    x_in  = 16'h8000;
    tick();
    start = 1'b0;
    x_in  = 16'h0000;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("m1_addr%0d", i), RW'(addr), RW'(exp_addr[i]));
      tick();
    end
    check("m1_done",  RW'(done), 32'd1);
    check("m1_model", result_ready, model(16'h8000));
    check("m1_tanh",  result_ready, q30(-0.76159416), TOL_ONE);
    tick();

    // start held for 25 cycles with x_in changing every cycle
    dcount = 0;
    for (int c = 0; c < 25; c++) xs[c] = 16'(16'h1357 * (c + 1));
    for (int c = 0; c < 36; c++) begin
      start = (c < 25);
      x_in  = (c < 25) ? xs[c] : 16'h0000;
      tick();
      if (done) begin
        if (dcount < 3) begin
          done_at[dcount]  = c;
          done_res[dcount] = result_ready;
        end
        dcount++;
      end
    end
    start = 1'b0;
    check("hold_done_count", RW'(dcount), 32'd3);
    for (int n = 0; n < 3; n++) begin
      if (n < dcount) begin
        check($sformatf("hold_done_at%0d", n), RW'(done_at[n]), RW'(10 * n + 9));
        check($sformatf("hold_res%0d", n), done_res[n], model(xs[10 * n]));
      end
    end

    // Asynchronous abort during HRN with k=3
    start = 1'b1;
    x_in  = 16'h4000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_addr", RW'(addr), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_addr",   RW'(addr), '0);
    check("abort_busy",   RW'(busy), '0);
    check("abort_done",   RW'(done), '0);
    check("abort_result", result_ready, '0);
    tick();
    tick();
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) dcount++;
    end
    check("abort_no_done", RW'(dcount), '0);
    run_op(16'h4000, res, edges, bcyc);
    check("abort_latency", RW'(edges), 32'd10);
    check("abort_res",     res, model(16'h4000));

    // Back-to-back start issued in DONE
    run_op(16'h2000, prev, edges, bcyc);
    start = 1'b1;
    x_in  = 16'hE000;
    tick();
    start = 1'b0;
    x_in  = 16'h1234;
    check("b2b_busy", RW'(busy), 32'd1);
    check("b2b_addr", RW'(addr), 32'd7);
    check("b2b_hold_early", result_ready, prev);
    edges = 1;
    while (!done && edges < 30) begin
      tick();
      edges++;
      if (edges == 9) check("b2b_hold_fin", result_ready, prev);
    end
    check("b2b_latency", RW'(edges), 32'd10);
    check("b2b_model",   result_ready, model(16'hE000));
    check("b2b_tanh",    result_ready, q30(-0.24491866), TOL_HALF);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
